// File: rtl/pam_mult_pkg.sv
// rtl/pam_mult_pkg.sv - shared types, constants and parameter checks for the PAM approximate multiplier
// Contents:
//   pam_mode_e      per-transaction mode (PAM_MODE_APPROX=0, PAM_MODE_EXACT=1)
//   pam_row_w       width of one compressed low-part row (W+1)
//   pam_l_ok        legality of the approximation level L for width W
//   pam_t_ok        legality of the truncation column T for width W
//   pam_params_ok   combined elaboration-time legality of W/L/T/TAG_W
package pam_mult_pkg;

    typedef enum logic {
        PAM_MODE_APPROX = 1'b0,
        PAM_MODE_EXACT  = 1'b1
    } pam_mode_e;

    // Two W-bit partial products offset by one column merge into W+1 columns.
    function automatic int pam_row_w(input int w);
        return w + 1;
    endfunction

    // Rows are approximated in pairs, so L must be even and cannot exceed W.
    function automatic bit pam_l_ok(input int w, input int l);
        return (l >= 0) && (l <= w) && ((l % 2) == 0);
    endfunction

    function automatic bit pam_t_ok(input int w, input int t);
        return (t >= 0) && (t <= 2 * w);
    endfunction

    function automatic bit pam_params_ok(input int w, input int l, input int t, input int tag_w);
        return (w >= 2) && pam_l_ok(w, l) && pam_t_ok(w, t) && (tag_w >= 1);
    endfunction

endpackage

// File: rtl/pam_approx_lowpart.sv
// rtl/pam_approx_lowpart.sv - combinational approximate low part A from x[L-1:0] and y
// Ports:
//   x_i   low L bits of the multiplier (1 bit wide when L=0, then ignored)
//   y_i   multiplicand
//   a_o   sum of OR-compressed row pairs, columns below T forced to zero
module pam_approx_lowpart
    import pam_mult_pkg::*;
#(
    parameter int W = 8,
    parameter int L = 6,
    parameter int T = 0
) (
    input  logic [((L > 0) ? L : 1)-1:0] x_i,
    input  logic [W-1:0]                 y_i,
    output logic [2*W-1:0]               a_o
);
    localparam int ZW = 2 * W;
    localparam int RW = pam_row_w(W);
    localparam int NR = L / 2;

    logic [ZW-1:0]        col_mask;
    logic [NR:0][ZW-1:0]  psum;

    for (genvar i = 0; i < ZW; i++) begin : g_mask
        assign col_mask[i] = (i >= T);
    end

    assign psum[0] = '0;

    // Row pair (2k, 2k+1): the odd row is shifted up one column and ORed with
    // the even row instead of added, which is where the approximation comes from.
    for (genvar k = 0; k < NR; k++) begin : g_row
        logic [RW-1:0] even_pp;
        logic [RW-1:0] odd_pp;
        assign even_pp     = {1'b0, y_i & {W{x_i[2*k]}}};
        assign odd_pp      = {y_i & {W{x_i[2*k+1]}}, 1'b0};
        assign psum[k+1]   = psum[k] + ((ZW'(even_pp | odd_pp) << (2 * k)) & col_mask);
    end

    assign a_o = psum[NR];

    if (L == 0) begin : g_no_rows
        logic unused_inputs;
        assign unused_inputs = ^{x_i, y_i};
    end

endmodule

// File: rtl/pam_approx_mult_pipe.sv
// rtl/pam_approx_mult_pipe.sv - three-stage approximate/exact unsigned multiplier with valid/ready
// Optional feature macro: PAM_ERR_CNT_EN (approximate-vs-exact mismatch counter on err_cnt)
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake; in_x (selects rows), in_y, in_exact, in_tag
//   out_valid / out_ready result handshake; out_z (2W bits), out_tag
//   err_cnt               saturating mismatch count; tied to 0 without PAM_ERR_CNT_EN
module pam_approx_mult_pipe
    import pam_mult_pkg::*;
#(
    parameter int W     = 8,
    parameter int L     = 6,
    parameter int T     = 0,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_exact,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      err_cnt
);
    localparam int ZW = 2 * W;
    localparam int LW = (L > 0) ? L : 1;

    if (!pam_params_ok(W, L, T, TAG_W)) begin : g_param_check
        $error("pam_approx_mult_pipe: illegal W/L/T/TAG_W combination");
    end

    logic             adv;

    logic             s1_valid_q;
    logic [W-1:0]     s1_x_q;
    logic [W-1:0]     s1_y_q;
    pam_mode_e        s1_mode_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic [W-1:0]     x_hi_d;
    logic [ZW-1:0]    h_d;
    logic [ZW-1:0]    a_d;
    logic [ZW-1:0]    p_d;

    logic             s2_valid_q;
    logic [ZW-1:0]    s2_h_q;
    logic [ZW-1:0]    s2_a_q;
    logic [ZW-1:0]    s2_p_q;
    pam_mode_e        s2_mode_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic             out_valid_q;
    logic [ZW-1:0]    out_z_q;
    logic [TAG_W-1:0] out_tag_q;

    // Whole pipe moves as one; it only freezes when a finished result is refused.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // S1: operands, mode and tag
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_mode_q  <= PAM_MODE_APPROX;
            s1_tag_q   <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_x_q    <= in_x;
                s1_y_q    <= in_y;
                s1_mode_q <= in_exact ? PAM_MODE_EXACT : PAM_MODE_APPROX;
                s1_tag_q  <= in_tag;
            end
        end
    end

    // High rows [W-1:L] are multiplied exactly; shifting x right by L drops the
    // approximated rows and the product is moved back to weight 2^L.
    assign x_hi_d = s1_x_q >> L;
    assign h_d    = (ZW'(x_hi_d) * ZW'(s1_y_q)) << L;
    assign p_d    = ZW'(s1_x_q) * ZW'(s1_y_q);

    pam_approx_lowpart #(
        .W (W),
        .L (L),
        .T (T)
    ) u_lowpart (
        .x_i (s1_x_q[LW-1:0]),
        .y_i (s1_y_q),
        .a_o (a_d)
    );

    // S2: high part, low part and exact product
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_h_q     <= '0;
            s2_a_q     <= '0;
            s2_p_q     <= '0;
            s2_mode_q  <= PAM_MODE_APPROX;
            s2_tag_q   <= '0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_h_q    <= h_d;
                s2_a_q    <= a_d;
                s2_p_q    <= p_d;
                s2_mode_q <= s1_mode_q;
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

    // S3: selected result; only loaded from a valid S2 slot so a bubble leaves
    // the last result on out_z.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_tag_q   <= '0;
        end else if (adv) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_z_q   <= (s2_mode_q == PAM_MODE_EXACT) ? s2_p_q : (s2_h_q + s2_a_q);
                out_tag_q <= s2_tag_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
    assign out_tag   = out_tag_q;

`ifdef PAM_ERR_CNT_EN
    logic        mis_d;
    logic        s2_mis_q;
    logic        s3_mis_q;
    logic [31:0] err_cnt_q;
    logic [31:0] err_cnt_d;

    // Compared for every transaction, whatever mode it asked for.
    assign mis_d = ((h_d + a_d) != p_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_mis_q <= 1'b0;
            s3_mis_q <= 1'b0;
        end else if (adv) begin
            if (s1_valid_q) begin
                s2_mis_q <= mis_d;
            end
            if (s2_valid_q) begin
                s3_mis_q <= s2_mis_q;
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_valid_q && out_ready && s3_mis_q && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_d = err_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_pam_approx_mult_pipe.sv
// tb/tb_pam_approx_mult_pipe.sv - self-checking bench for pam_approx_mult_pipe (T=0 and T=2 instances)
module tb_pam_approx_mult_pipe;
    localparam int W     = 8;
    localparam int L     = 6;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [W-1:0]     in_x;
    logic [W-1:0]     in_y;
    logic             in_exact;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             in_ready0, in_ready2;
    logic             out_valid0, out_valid2;
    logic [2*W-1:0]   out_z0, out_z2;
    logic [TAG_W-1:0] out_tag0, out_tag2;
    logic [31:0]      err0, err2;

    int n_pass  = 0;
    int n_total = 0;
    int n_acc   = 0;
    int n_emit  = 0;

    typedef struct {
        longint z0;
        longint z2;
        int     tag;
        bit     m0;
        bit     m2;
    } exp_t;

    exp_t   q[$];
    exp_t   e_new;
    longint err0_m = 0;
    longint err2_m = 0;
    longint ex_new;

    always #5 clk = ~clk;

    pam_approx_mult_pipe #(.W(W), .L(L), .T(0), .TAG_W(TAG_W)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_x(in_x), .in_y(in_y), .in_exact(in_exact), .in_tag(in_tag),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_z(out_z0), .out_tag(out_tag0), .err_cnt(err0)
    );

    pam_approx_mult_pipe #(.W(W), .L(L), .T(2), .TAG_W(TAG_W)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_x(in_x), .in_y(in_y), .in_exact(in_exact), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_z(out_z2), .out_tag(out_tag2), .err_cnt(err2)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Column-by-column evaluation of the approximation rules.
    function automatic longint model_approx(input longint x, input longint y, input int t);
        longint h, a, b;
        int     col;
        h = ((x >> L) * y) << L;
        a = 0;
        for (int k = 0; k < L / 2; k++) begin
            for (int j = 0; j <= W; j++) begin
                col = 2 * k + j;
                b = (y >> j) & (x >> (2 * k)) & 1;
                if (j > 0) b = b | ((y >> (j - 1)) & (x >> (2 * k + 1)) & 1);
                if (col >= t) a = a + (b << col);
            end
        end
        return (h + a) & ((longint'(1) << (2 * W)) - 1);
    endfunction

    // Compare process: model queue in acceptance order, checked every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                err0_m = 0;
                err2_m = 0;
                n_acc  = 0;
                n_emit = 0;
            end else begin
                check("in_ready_rule", in_ready0, (!out_valid0 || out_ready));
                check("in_ready_t2", in_ready2, in_ready0);
                check("out_valid_t2", out_valid2, out_valid0);
                if (q.size() == 0) begin
                    check("no_stale_result", out_valid0, 0);
                end else if (out_valid0) begin
                    check("z_t0", out_z0, q[0].z0);
                    check("z_t2", out_z2, q[0].z2);
                    check("tag_t0", out_tag0, q[0].tag);
                    check("tag_t2", out_tag2, q[0].tag);
                end
                check("err_t0", err0, err0_m);
                check("err_t2", err2, err2_m);
                if (out_valid0 && out_ready && q.size() > 0) begin
`ifdef PAM_ERR_CNT_EN
                    if (q[0].m0 && err0_m != 64'hFFFF_FFFF) err0_m = err0_m + 1;
                    if (q[0].m2 && err2_m != 64'hFFFF_FFFF) err2_m = err2_m + 1;
`endif
                    void'(q.pop_front());
                    n_emit++;
                end
                if (in_valid && in_ready0) begin
                    ex_new    = longint'(in_x) * longint'(in_y);
                    e_new.m0  = (model_approx(in_x, in_y, 0) != ex_new);
                    e_new.m2  = (model_approx(in_x, in_y, 2) != ex_new);
                    e_new.z0  = in_exact ? ex_new : model_approx(in_x, in_y, 0);
                    e_new.z2  = in_exact ? ex_new : model_approx(in_x, in_y, 2);
                    e_new.tag = int'(in_tag);
                    q.push_back(e_new);
                    n_acc++;
                end
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic push(input logic [W-1:0] x, input logic [W-1:0] y, input logic ex,
                        input logic [TAG_W-1:0] tag);
        bit acc;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_exact = ex;
        in_tag   = tag;
        acc      = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1;
        end
        if (!acc) check("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic ex,
                           input logic [TAG_W-1:0] tag, input longint e0, input longint e2);
        bit got;
        push(x, y, ex, tag);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = out_valid0;
        end
        check("directed_done", got, 1);
        check("directed_z_t0", out_z0, e0);
        check("directed_z_t2", out_z2, e2);
        check("directed_tag", out_tag0, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [2*W-1:0]   hold_z;
    logic [TAG_W-1:0] hold_tag;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_exact  = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid0, 0);
        check("reset_out_z", out_z0, 0);
        check("reset_out_tag", out_tag0, 0);
        check("reset_err_cnt", err0, 0);
        check("reset_in_ready", in_ready0, 1);
        @(posedge clk);
        #1;

        run_one(8'hFF, 8'hFF, 1'b0, 4'h1, 59691, 59688);
        run_one(8'hFF, 8'hFF, 1'b1, 4'h2, 65025, 65025);
        run_one(8'h03, 8'h03, 1'b0, 4'h3, 7, 4);
        run_one(8'h03, 8'h03, 1'b1, 4'h4, 9, 9);
        run_one(8'h40, 8'h03, 1'b0, 4'h5, 192, 192);
        run_one(8'h40, 8'h03, 1'b1, 4'h6, 192, 192);

`ifdef PAM_ERR_CNT_EN
        pulse_reset();
        run_one(8'hFF, 8'hFF, 1'b0, 4'h1, 59691, 59688);
        run_one(8'h03, 8'h03, 1'b0, 4'h2, 7, 4);
        run_one(8'h40, 8'h03, 1'b0, 4'h3, 192, 192);
        @(negedge clk);
        check("err_cnt_two", err0, 2);
        @(posedge clk);
        #1;
        force dut0.err_cnt_q = 32'hFFFF_FFFF;
        err0_m = 64'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut0.err_cnt_q;
        run_one(8'hFF, 8'hFF, 1'b0, 4'h4, 59691, 59688);
        @(negedge clk);
        check("err_cnt_saturated", err0, 64'hFFFF_FFFF);
        @(posedge clk);
        #1;
`else
        @(negedge clk);
        check("err_cnt_tied_zero", err0, 0);
        @(posedge clk);
        #1;
`endif

        // Back-to-back stream: item c presented in cycle c, result in cycle c+3.
        out_ready = 1'b1;
        for (int c = 0; c < 21; c++) begin
            if (c < 16) begin
                in_valid = 1'b1;
                in_x     = 8'(c * 17 + 3);
                in_y     = 8'(255 - c * 13);
                in_exact = c[0];
                in_tag   = c[TAG_W-1:0];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("stream_in_ready", in_ready0, 1);
            check("stream_out_valid", out_valid0, (c >= 3 && c <= 18));
            if (out_valid0) check("stream_tag", out_tag0, (c - 3) & 15);
            @(posedge clk);
            #1;
        end

        // Reset with two transactions in flight.
        push(8'hFF, 8'hFF, 1'b0, 4'h7);
        push(8'h03, 8'h03, 1'b0, 4'h8);
        pulse_reset();
        @(negedge clk);
        check("midreset_out_valid", out_valid0, 0);
        check("midreset_out_z", out_z0, 0);
        check("midreset_out_tag", out_tag0, 0);
        check("midreset_err_cnt", err0, 0);
        check("midreset_in_ready", in_ready0, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midreset_no_stale", out_valid0, 0);
        end
        @(posedge clk);
        #1;

        // Fill the pipe with the consumer stalled, then hold for 5 cycles.
        out_ready = 1'b0;
        push(8'h12, 8'h34, 1'b0, 4'hA);
        push(8'hFF, 8'hFF, 1'b0, 4'hB);
        push(8'h03, 8'h03, 1'b1, 4'hC);
        in_valid = 1'b1;
        in_x     = 8'h40;
        in_y     = 8'h03;
        in_exact = 1'b0;
        in_tag   = 4'hD;
        @(negedge clk);
        check("hold_out_valid", out_valid0, 1);
        check("hold_in_ready", in_ready0, 0);
        check("hold_first_tag", out_tag0, 4'hA);
        hold_z   = out_z0;
        hold_tag = out_tag0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("hold_in_ready_low", in_ready0, 0);
            check("hold_z_stable", out_z0, hold_z);
            check("hold_tag_stable", out_tag0, hold_tag);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("drain_queue_empty", q.size(), 0);
        check("drain_no_loss_no_dup", n_emit, n_acc);
        check("drain_count", n_acc, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
